button_debounce: RTL and testbench

Input-side counterpart to the LED drivers. It synchronises N raw push-button/switch inputs into the 100 MHz `clk` domain and filters contact bounce. It publishes a clean level per channel, plus single-cycle press, release and long-press pulses. It sits between board pins and any control logic, such as blink-rate selection or protocol test triggers.

---
 rtl/debounce_pkg.sv | 23 ++
 rtl/debounce_channel.sv | 137 +++++++++++++
 rtl/button_debounce.sv | 38 +++
 tb/tb_button_debounce.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the button debouncer.
// Latency: n/a (package only).
// Backpressure: n/a; no flow control anywhere in this block.
package debounce_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRESS_PEND,
      PRESSED,
      LONG_HELD,
      RELEASE_PEND
   } db_state_t;

   localparam int CLK_HZ              = 100_000_000;
   localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;   // 10 ms
   localparam int LONG_CYCLES_DEF     = CLK_HZ;         // 1 s

   // Counter width for a count of n cycles; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM, hold counter.
// Latency: press/release visible DEBOUNCE_CYCLES+1 edges after first raw sample.
// Backpressure: none; pulses are fire-and-forget, one cycle wide.
//
// Ports: clk, rst (async, active high), btn (raw input), level (debounced),
//        press_pulse / release_pulse / long_pulse (single-cycle events).
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse
);

   localparam int DW = cnt_width(DEBOUNCE_CYCLES);
   localparam int HW = cnt_width(LONG_CYCLES);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
   localparam logic [DW-1:0] D_ONE  = DW'(1);

   logic          s1, s2;
   db_state_t     state;
   logic [DW-1:0] dcnt;
   logic [HW-1:0] hcnt;
   // Long pulse already issued for this press; also selects where an
   // aborted release returns to.
   logic          held_long;

   // Hold timer runs in every level-1 state until the long pulse fires.
   logic hold_fire;
   assign hold_fire = !held_long && (hcnt == H_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1            <= 1'b0;
         s2            <= 1'b0;
         state         <= IDLE;
         dcnt          <= '0;
         hcnt          <= '0;
         held_long     <= 1'b0;
         level         <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
      end else begin
         s1            <= btn;
         s2            <= s1;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;

         case (state)
            IDLE: begin
               if (s2) begin
                  state <= PRESS_PEND;
                  dcnt  <= D_ONE;
               end
            end

            PRESS_PEND: begin
               if (!s2) begin
                  state <= IDLE;
                  dcnt  <= '0;
               end else if (dcnt == D_LAST) begin
                  state       <= PRESSED;
                  level       <= 1'b1;
                  press_pulse <= 1'b1;
                  dcnt        <= '0;
                  hcnt        <= '0;
                  held_long   <= 1'b0;
               end else begin
                  dcnt <= dcnt + 1'b1;
               end
            end

            PRESSED: begin
               if (!s2) begin
                  state <= RELEASE_PEND;
                  dcnt  <= D_ONE;
               end else if (hold_fire) begin
                  state <= LONG_HELD;
               end
               if (hold_fire) begin
                  long_pulse <= 1'b1;
                  held_long  <= 1'b1;
               end else begin
                  hcnt <= hcnt + 1'b1;
               end
            end

            LONG_HELD: begin
               if (!s2) begin
                  state <= RELEASE_PEND;
                  dcnt  <= D_ONE;
               end
            end

            RELEASE_PEND: begin
               if (!s2 && dcnt == D_LAST) begin
                  // Release wins over a coincident long expiry so the
                  // pulses stay mutually exclusive.
                  state         <= IDLE;
                  level         <= 1'b0;
                  release_pulse <= 1'b1;
                  dcnt          <= '0;
                  hcnt          <= '0;
                  held_long     <= 1'b0;
               end else begin
                  if (s2) begin
                     state <= (held_long || hold_fire) ? LONG_HELD : PRESSED;
                     dcnt  <= '0;
                  end else begin
                     dcnt <= dcnt + 1'b1;
                  end
                  // Level is still 1 here, so the hold timer keeps running.
                  if (hold_fire) begin
                     long_pulse <= 1'b1;
                     held_long  <= 1'b1;
                  end else if (!held_long) begin
                     hcnt <= hcnt + 1'b1;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/button_debounce.sv
// N independent debounced button channels.
// Latency: DEBOUNCE_CYCLES+1 edges from first raw sample to level/press/release.
// Backpressure: none; outputs are levels and single-cycle pulses.
//
// Ports: clk, rst (async, active high), btn_in[N] raw inputs (1 = pressed),
//        btn_level, btn_press, btn_release, btn_long (all N wide, registered).
module button_debounce
   import debounce_pkg::*;
#(
   parameter int N               = 4,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] btn_in,
   output logic [N-1:0] btn_level,
   output logic [N-1:0] btn_press,
   output logic [N-1:0] btn_release,
   output logic [N-1:0] btn_long
);

   for (genvar i = 0; i < N; i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES)
      ) u_ch (
         .clk           (clk),
         .rst           (rst),
         .btn           (btn_in[i]),
         .level         (btn_level[i]),
         .press_pulse   (btn_press[i]),
         .release_pulse (btn_release[i]),
         .long_pulse    (btn_long[i])
      );
   end

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce (N=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10).
// Stimulus pushes expected events tagged with the edge number they must appear
// after; the monitor matches every observed pulse and level check against them.
module tb_button_debounce;

   localparam int N  = 2;
   localparam int DC = 4;
   localparam int LC = 10;

   localparam int K_PRESS   = 0;
   localparam int K_RELEASE = 1;
   localparam int K_LONG    = 2;
   localparam int K_LEVEL   = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [N-1:0] btn_in = '0;
   logic [N-1:0] btn_level, btn_press, btn_release, btn_long;

   button_debounce #(.N(N), .DEBOUNCE_CYCLES(DC), .LONG_CYCLES(LC)) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_in      (btn_in),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_long    (btn_long)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int ch;
      int kind;
      int val;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;   // number of rising edges so far

   always @(posedge clk) cyc <= cyc + 1;

   function automatic string kname(input int k);
      case (k)
         K_PRESS:   return "press";
         K_RELEASE: return "release";
         K_LONG:    return "long";
         default:   return "level";
      endcase
   endfunction

   function automatic logic pulse_of(input int k, input int ch);
      case (k)
         K_PRESS:   return btn_press[ch];
         K_RELEASE: return btn_release[ch];
         default:   return btn_long[ch];
      endcase
   endfunction

   function automatic void exp_ev(input int c, input int ch, input int k, input int v);
      exp_t e;
      e.cyc = c; e.ch = ch; e.kind = k; e.val = v;
      sb.push_back(e);
   endfunction

   // Monitor: sampled on the falling edge, half a cycle after outputs update.
   int found;
   always @(negedge clk) begin
      for (int ch = 0; ch < N; ch++) begin
         for (int k = 0; k < 3; k++) begin
            if (pulse_of(k, ch) !== 1'b0) begin
               found = -1;
               for (int j = 0; j < sb.size(); j++)
                  if (sb[j].kind == k && sb[j].ch == ch && sb[j].cyc == cyc) found = j;
               total++;
               if (found < 0) begin
                  bad++;
                  $display("FAIL unexpected_%s ch%0d edge %0d: got %b, required 0",
                           kname(k), ch, cyc, pulse_of(k, ch));
               end else begin
                  sb.delete(found);
               end
            end
         end
      end
      for (int j = sb.size() - 1; j >= 0; j--) begin
         if (sb[j].kind == K_LEVEL && sb[j].cyc == cyc) begin
            total++;
            if (btn_level[sb[j].ch] !== 1'(sb[j].val)) begin
               bad++;
               $display("FAIL level ch%0d edge %0d: got %b, required %0d",
                        sb[j].ch, cyc, btn_level[sb[j].ch], sb[j].val);
            end
            sb.delete(j);
         end
      end
      for (int j = sb.size() - 1; j >= 0; j--) begin
         if (sb[j].cyc <= cyc) begin
            total++;
            bad++;
            $display("FAIL missing_%s ch%0d edge %0d: got 0, required 1",
                     kname(sb[j].kind), sb[j].ch, sb[j].cyc);
            sb.delete(j);
         end
      end
   end

   // Reset must clear every output without waiting for a clock edge.
   always @(posedge rst) begin
      #1;
      total++;
      if ({btn_level, btn_press, btn_release, btn_long} !== '0) begin
         bad++;
         $display("FAIL async_reset at time %0t: got lvl=%b prs=%b rel=%b lng=%b, required all 0",
                  $time, btn_level, btn_press, btn_release, btn_long);
      end
   end

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   int c, c2;
   logic [6:0] bounce;

   initial begin
      #1 rst = 1'b1;
      wait_neg(3);
      rst = 1'b0;
      exp_ev(cyc + 2, 0, K_LEVEL, 0);
      exp_ev(cyc + 2, 1, K_LEVEL, 0);
      wait_neg(3);

      // Clean press and release on channel 0; channel 1 stays idle.
      c = cyc;
      btn_in[0] = 1'b1;
      exp_ev(c + 5, 0, K_LEVEL, 0);
      exp_ev(c + 6, 0, K_PRESS, 1);
      exp_ev(c + 6, 0, K_LEVEL, 1);
      exp_ev(c + 6, 1, K_LEVEL, 0);
      wait_neg(8);
      c = cyc;
      btn_in[0] = 1'b0;
      exp_ev(c + 5, 0, K_LEVEL, 1);
      exp_ev(c + 6, 0, K_RELEASE, 1);
      exp_ev(c + 6, 0, K_LEVEL, 0);
      wait_neg(10);

      // Bounce shorter than the debounce window is ignored.
      bounce = 7'b0111011;   // applied LSB first: 1,1,0,1,1,1,0
      c = cyc;
      exp_ev(c + 3, 0, K_LEVEL, 0);
      exp_ev(c + 7, 0, K_LEVEL, 0);
      exp_ev(c + 10, 0, K_LEVEL, 0);
      for (int i = 0; i < 7; i++) begin
         btn_in[0] = bounce[i];
         wait_neg(1);
      end
      wait_neg(3);
      c = cyc;
      btn_in[0] = 1'b1;
      exp_ev(c + 6, 0, K_PRESS, 1);
      wait_neg(7);
      c = cyc;
      btn_in[0] = 1'b0;
      exp_ev(c + 6, 0, K_RELEASE, 1);
      wait_neg(10);

      // Long press on channel 1, held well past the long point.
      c = cyc;
      btn_in[1] = 1'b1;
      exp_ev(c + 6, 1, K_PRESS, 1);
      exp_ev(c + 16, 1, K_LONG, 1);
      exp_ev(c + 15, 1, K_LEVEL, 1);
      wait_neg(20);
      c2 = cyc;
      btn_in[1] = 1'b0;
      exp_ev(c2 + 5, 1, K_LEVEL, 1);
      exp_ev(c2 + 6, 1, K_RELEASE, 1);
      exp_ev(c2 + 6, 1, K_LEVEL, 0);
      wait_neg(10);

      // Two-cycle low glitch while pressed; hold timer keeps running.
      c = cyc;
      btn_in[1] = 1'b1;
      exp_ev(c + 6, 1, K_PRESS, 1);
      exp_ev(c + 16, 1, K_LONG, 1);
      wait_neg(8);
      btn_in[1] = 1'b0;
      wait_neg(2);
      btn_in[1] = 1'b1;
      exp_ev(c + 12, 1, K_LEVEL, 1);
      exp_ev(c + 14, 1, K_LEVEL, 1);
      wait_neg(10);
      c2 = cyc;
      btn_in[1] = 1'b0;
      exp_ev(c2 + 6, 1, K_RELEASE, 1);
      wait_neg(10);

      // Reset during PRESS_PEND with the button held through it.
      c = cyc;
      btn_in[0] = 1'b1;
      wait_neg(3);
      #2 rst = 1'b1;
      exp_ev(c + 4, 0, K_LEVEL, 0);
      wait_neg(2);
      rst = 1'b0;
      c2 = cyc;
      exp_ev(c2 + 5, 0, K_LEVEL, 0);
      exp_ev(c2 + 6, 0, K_PRESS, 1);
      exp_ev(c2 + 16, 0, K_LONG, 1);
      wait_neg(19);
      // Now in LONG_HELD: reset again, releasing the button meanwhile.
      exp_ev(cyc, 0, K_LEVEL, 1);
      wait_neg(1);
      #2 rst = 1'b1;
      btn_in[0] = 1'b0;
      wait_neg(2);
      rst = 1'b0;
      exp_ev(cyc + 1, 0, K_LEVEL, 0);
      exp_ev(cyc + 8, 0, K_LEVEL, 0);
      wait_neg(10);

      // Both channels, two cycles apart.
      c = cyc;
      btn_in[0] = 1'b1;
      exp_ev(c + 6, 0, K_PRESS, 1);
      wait_neg(2);
      btn_in[1] = 1'b1;
      exp_ev(c + 8, 1, K_PRESS, 1);
      exp_ev(c + 7, 1, K_LEVEL, 0);
      exp_ev(c + 7, 0, K_LEVEL, 1);
      wait_neg(6);
      btn_in[0] = 1'b0;
      exp_ev(c + 14, 0, K_RELEASE, 1);
      wait_neg(2);
      btn_in[1] = 1'b0;
      exp_ev(c + 16, 1, K_RELEASE, 1);
      exp_ev(c + 15, 1, K_LEVEL, 1);
      exp_ev(c + 15, 0, K_LEVEL, 0);
      wait_neg(12);

      while (sb.size() > 0) begin
         total++;
         bad++;
         $display("FAIL leftover_%s ch%0d edge %0d: got nothing, required event",
                  kname(sb[0].kind), sb[0].ch, sb[0].cyc);
         void'(sb.pop_front());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
